bp_be_issue_queue: RTL and testbench

//  Speculative FIFO between the FE->BE fetch interface and the BE instruction decoder.
//  - Buffers fetch packets (instr, pc, fe exception) and presents the oldest unread packet to the decoder.
//  - Keeps a committed pointer, so that on a mispredict or trap the read pointer rolls back and

---
 rtl/bp_be_pkg.sv | 23 ++
 rtl/bp_be_issue_queue_mem.sv | 24 ++
 rtl/bp_be_issue_queue.sv | 90 +++++++++
 tb/tb_bp_be_issue_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types for the backend issue queue
package bp_be_pkg;

    localparam int bp_be_vaddr_width_gp = 39;

    typedef enum logic [2:0] {
        e_instr_misaligned   = 3'd0,
        e_itlb_miss          = 3'd1,
        e_instr_page_fault   = 3'd2,
        e_instr_access_fault = 3'd3,
        e_icache_miss        = 3'd4
    } bp_fe_exception_code_e;

    typedef struct packed {
        logic [31:0]                     instr;
        logic [bp_be_vaddr_width_gp-1:0] pc;
        logic                            exc_v;
        logic [2:0]                      exc;
    } bp_be_issue_pkt_s;

endpackage

`define BP_BE_ISSUE_PKT_WIDTH(vaddr_width_mp) (32 + (vaddr_width_mp) + 1 + 3)

// File: rtl/bp_be_issue_queue_mem.sv
// rtl/bp_be_issue_queue_mem.sv - packet storage, one sync write port and one async read port
module bp_be_issue_queue_mem #(
    parameter int els_p   = 8,
    parameter int width_p = 75
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] r_mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            r_mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_mem[r_addr_i];

endmodule

// File: rtl/bp_be_issue_queue.sv
// rtl/bp_be_issue_queue.sv - speculative fetch-to-decode queue with commit pointer and replay
module bp_be_issue_queue
    import bp_be_pkg::*;
#(
    parameter int els_p         = 8,
    parameter int vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     enq_v_i,
    output logic                     enq_ready_o,
    input  logic [31:0]              enq_instr_i,
    input  logic [vaddr_width_p-1:0] enq_pc_i,
    input  logic                     enq_exc_v_i,
    input  logic [2:0]               enq_exc_i,
    output logic                     deq_v_o,
    input  logic                     deq_yumi_i,
    output logic [31:0]              deq_instr_o,
    output logic [vaddr_width_p-1:0] deq_pc_o,
    output logic                     deq_exc_v_o,
    output logic [2:0]               deq_exc_o,
    input  logic                     cmt_v_i,
    input  logic                     roll_v_i,
    input  logic                     clr_v_i,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = idx_w_lp + 1;
    localparam int pkt_w_lp = `BP_BE_ISSUE_PKT_WIDTH(vaddr_width_p);

    logic [ptr_w_lp-1:0] r_wptr, r_rptr, r_cptr;
    logic [ptr_w_lp-1:0] w_cptr_cmt;
    logic                w_full, w_empty, w_enq, w_deq, w_cmt;
    logic [pkt_w_lp-1:0] w_rdata;

    // Full is measured against the commit pointer: read-but-uncommitted slots are still owned.
    assign w_full  = (r_wptr[idx_w_lp-1:0] == r_cptr[idx_w_lp-1:0])
                   & (r_wptr[idx_w_lp] != r_cptr[idx_w_lp]);
    assign w_empty = (r_wptr == r_rptr);

    assign enq_ready_o = ~w_full & ~clr_v_i & reset_n_i;
    assign deq_v_o     = ~w_empty & ~roll_v_i & ~clr_v_i;
    assign empty_o     = w_empty;
    assign full_o      = w_full;

    assign w_enq      = enq_v_i & enq_ready_o;
    assign w_deq      = deq_yumi_i & deq_v_o;
    assign w_cmt      = cmt_v_i & (r_cptr != r_rptr);
    assign w_cptr_cmt = r_cptr + ptr_w_lp'(w_cmt);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else if (clr_v_i) begin
            r_rptr <= r_wptr;
            r_cptr <= r_wptr;
        end else begin
            r_wptr <= r_wptr + ptr_w_lp'(w_enq);
            r_cptr <= w_cptr_cmt;
            r_rptr <= roll_v_i ? w_cptr_cmt : (r_rptr + ptr_w_lp'(w_deq));
        end
    end

    bp_be_issue_queue_mem #(
        .els_p   (els_p),
        .width_p (pkt_w_lp)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (w_enq),
        .w_addr_i (r_wptr[idx_w_lp-1:0]),
        .w_data_i ({enq_instr_i, enq_pc_i, enq_exc_v_i, enq_exc_i}),
        .r_addr_i (r_rptr[idx_w_lp-1:0]),
        .r_data_o (w_rdata)
    );

    assign {deq_instr_o, deq_pc_o, deq_exc_v_o, deq_exc_o} = w_rdata;

    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(deq_yumi_i && !deq_v_o))
        else $error("deq_yumi_i asserted without deq_v_o");

    a_cmt_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(cmt_v_i && !clr_v_i && (r_cptr == r_rptr)))
        else $error("cmt_v_i with no read-but-uncommitted packet");

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// tb/tb_bp_be_issue_queue.sv - randomized and directed checks of bp_be_issue_queue against a packet-list model
module tb_bp_be_issue_queue;
    import bp_be_pkg::*;

    localparam int ELS = 8;
    localparam int VA  = 39;

    typedef struct packed {
        logic [31:0]   instr;
        logic [VA-1:0] pc;
        logic          excv;
        logic [2:0]    exc;
    } pkt_t;

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          enq_v_i = 1'b0, enq_exc_v_i = 1'b0;
    logic [31:0]   enq_instr_i = '0;
    logic [VA-1:0] enq_pc_i = '0;
    logic [2:0]    enq_exc_i = '0;
    logic          deq_yumi_i = 1'b0, cmt_v_i = 1'b0, roll_v_i = 1'b0, clr_v_i = 1'b0;
    logic          enq_ready_o, deq_v_o, deq_exc_v_o, empty_o, full_o;
    logic [31:0]   deq_instr_o;
    logic [VA-1:0] deq_pc_o;
    logic [2:0]    deq_exc_o;

    bp_be_issue_queue #(.els_p(ELS), .vaddr_width_p(VA)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .enq_v_i(enq_v_i), .enq_ready_o(enq_ready_o), .enq_instr_i(enq_instr_i),
        .enq_pc_i(enq_pc_i), .enq_exc_v_i(enq_exc_v_i), .enq_exc_i(enq_exc_i),
        .deq_v_o(deq_v_o), .deq_yumi_i(deq_yumi_i), .deq_instr_o(deq_instr_o),
        .deq_pc_o(deq_pc_o), .deq_exc_v_o(deq_exc_v_o), .deq_exc_o(deq_exc_o),
        .cmt_v_i(cmt_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i),
        .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    // Model: held = packets written but not yet committed, oldest first; nread of them have been read.
    pkt_t held[$];
    int   nread = 0;
    bit   chk_en = 1'b0;
    int   n_vec = 0, n_bad = 0;
    pkt_t exp_p;

    function automatic bit m_ready();
        return (held.size() < ELS) && !clr_v_i && reset_n_i;
    endfunction

    function automatic bit m_deq_v();
        return (nread < held.size()) && !roll_v_i && !clr_v_i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("enq_ready", 64'(enq_ready_o), 64'(m_ready()));
            check("deq_v", 64'(deq_v_o), 64'(m_deq_v()));
            check("empty", 64'(empty_o), 64'(nread == held.size()));
            check("full", 64'(full_o), 64'(held.size() == ELS));
            if (m_deq_v()) begin
                exp_p = held[nread];
                check("deq_instr", 64'(deq_instr_o), 64'(exp_p.instr));
                check("deq_pc", 64'(deq_pc_o), 64'(exp_p.pc));
                check("deq_exc_v", 64'(deq_exc_v_o), 64'(exp_p.excv));
                check("deq_exc", 64'(deq_exc_o), 64'(exp_p.exc));
            end
        end
    end

    task automatic model_update();
        bit   rdy, dv;
        pkt_t p;
        rdy = m_ready();
        dv  = m_deq_v();
        if (clr_v_i) begin
            held.delete();
            nread = 0;
        end else begin
            if (roll_v_i) begin
                if (cmt_v_i && nread > 0) void'(held.pop_front());
                nread = 0;
            end else begin
                int n0 = nread;
                if (deq_yumi_i && dv) nread++;
                if (cmt_v_i && n0 > 0) begin
                    void'(held.pop_front());
                    nread--;
                end
            end
            if (enq_v_i && rdy) begin
                p.instr = enq_instr_i; p.pc = enq_pc_i; p.excv = enq_exc_v_i; p.exc = enq_exc_i;
                held.push_back(p);
            end
        end
    endtask

    task automatic drive(input bit ev, input logic [31:0] ins, input logic [VA-1:0] pc,
                         input bit xv, input logic [2:0] x,
                         input bit y, input bit c, input bit r, input bit cl);
        enq_v_i = ev; enq_instr_i = ins; enq_pc_i = pc; enq_exc_v_i = xv; enq_exc_i = x;
        deq_yumi_i = y; cmt_v_i = c; roll_v_i = r; clr_v_i = cl;
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic enq(input logic [VA-1:0] pc);
        drive(1, $urandom, pc, 0, 3'd0, 0, 0, 0, 0);
        step();
    endtask

    task automatic op(input bit y, input bit c, input bit r, input bit cl);
        drive(0, 32'd0, '0, 0, 3'd0, y, c, r, cl);
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_deq_v", 64'(deq_v_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_enq_ready", 64'(enq_ready_o), 64'd0);
        reset_n_i = 1'b1;
        chk_en = 1'b1;

        // 1: first packet visible one cycle after enqueue
        drive(1, 32'h13, 39'h8000_0000, 0, 3'd0, 0, 0, 0, 0);
        check("t1_deq_v_same", 64'(deq_v_o), 64'd0);
        step();
        drive(1, 32'h14, 39'h8000_0004, 0, 3'd0, 0, 0, 0, 0);
        check("t1_deq_v", 64'(deq_v_o), 64'd1);
        check("t1_deq_pc", 64'(deq_pc_o), 64'h8000_0000);
        check("t1_empty", 64'(empty_o), 64'd0);
        step();
        enq(39'h8000_0008);

        // 2: fill, drain, commit frees one slot across the wrap
        for (int i = 0; i < 5; i++) enq(39'h8000_000c + 39'(4 * i));
        drive(1, 32'h1, 39'h9999, 0, 3'd0, 0, 0, 0, 0);
        check("t2_full", 64'(full_o), 64'd1);
        check("t2_ready", 64'(enq_ready_o), 64'd0);
        step();
        for (int i = 0; i < 8; i++) op(1, 0, 0, 0);
        drive(0, 32'd0, '0, 0, 3'd0, 0, 1, 0, 0);
        check("t2_full_cmt", 64'(full_o), 64'd1);
        check("t2_ready_cmt", 64'(enq_ready_o), 64'd0);
        step();
        drive(0, 32'd0, '0, 0, 3'd0, 0, 0, 0, 0);
        check("t2_full_after", 64'(full_o), 64'd0);
        check("t2_ready_after", 64'(enq_ready_o), 64'd1);
        step();
        enq(39'h7777_0000);
        drive(0, 32'd0, '0, 0, 3'd0, 0, 0, 0, 0);
        check("t2_wrap_pc", 64'(deq_pc_o), 64'h7777_0000);
        step();
        op(0, 0, 0, 1);

        // 3: replay after partial commit
        enq(39'h1000); enq(39'h1004); enq(39'h1008);
        op(1, 0, 0, 0);
        op(1, 1, 0, 0);
        drive(0, 32'd0, '0, 0, 3'd0, 0, 0, 1, 0);
        check("t3_roll_deq_v", 64'(deq_v_o), 64'd0);
        step();
        drive(0, 32'd0, '0, 0, 3'd0, 1, 0, 0, 0);
        check("t3_replay_b", 64'(deq_pc_o), 64'h1004);
        step();
        drive(0, 32'd0, '0, 0, 3'd0, 1, 0, 0, 0);
        check("t3_replay_c", 64'(deq_pc_o), 64'h1008);
        step();
        op(0, 0, 0, 1);

        // 4: commit and roll in the same cycle
        enq(39'h2000); enq(39'h2004);
        op(1, 0, 0, 0); op(1, 0, 0, 0);
        op(0, 1, 1, 0);
        drive(0, 32'd0, '0, 0, 3'd0, 0, 0, 0, 0);
        check("t4_deq_v", 64'(deq_v_o), 64'd1);
        check("t4_deq_pc", 64'(deq_pc_o), 64'h2004);
        step();
        op(0, 0, 0, 1);

        // 5: clear drops a same-cycle enqueue
        for (int i = 0; i < 5; i++) enq(39'h3000 + 39'(4 * i));
        drive(1, 32'h5, 39'h3100, 0, 3'd0, 0, 0, 0, 1);
        check("t5_ready_clr", 64'(enq_ready_o), 64'd0);
        step();
        drive(0, 32'd0, '0, 0, 3'd0, 0, 0, 0, 0);
        check("t5_empty", 64'(empty_o), 64'd1);
        check("t5_full", 64'(full_o), 64'd0);
        check("t5_deq_v", 64'(deq_v_o), 64'd0);
        step();

        // 6: asynchronous reset mid-stream, then an exception packet
        for (int i = 0; i < 4; i++) enq(39'h5000 + 39'(4 * i));
        drive(0, 32'd0, '0, 0, 3'd0, 0, 0, 0, 0);
        chk_en = 1'b0;
        reset_n_i = 1'b0;
        #1;
        check("t6_deq_v", 64'(deq_v_o), 64'd0);
        check("t6_empty", 64'(empty_o), 64'd1);
        check("t6_ready", 64'(enq_ready_o), 64'd0);
        held.delete();
        nread = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        chk_en = 1'b1;
        drive(1, 32'hdead_beef, 39'h4000, 1, e_itlb_miss, 0, 0, 0, 0);
        step();
        drive(0, 32'd0, '0, 0, 3'd0, 0, 0, 0, 0);
        check("t6_exc_v", 64'(deq_exc_v_o), 64'd1);
        check("t6_exc", 64'(deq_exc_o), 64'(e_itlb_miss));
        check("t6_pc", 64'(deq_pc_o), 64'h4000);
        check("t6_instr", 64'(deq_instr_o), 64'hdead_beef);
        step();

        // Random traffic; only legal yumi/commit are driven
        for (int k = 0; k < 3000; k++) begin
            bit ev, y, c, r, cl;
            ev = ($urandom_range(0, 9) < 6);
            r  = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 49) == 0);
            y  = ($urandom_range(0, 1) == 1) && (nread < held.size()) && !r && !cl;
            c  = ($urandom_range(0, 2) == 0) && (nread > 0);
            drive(ev, $urandom, {$urandom, $urandom} & {VA{1'b1}}, $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 4)), y, c, r, cl);
            step();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
